// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the hazard controller (slave).
// The master side supplies ID/EX operand info and memory status; the slave side returns the stage enables.
interface pipeline_hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_branch_taken;
  logic       mem_busy;
  logic       pc_ce;
  logic       if_id_ce;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic       pipe_hold;
  logic       mem_timeout;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_busy,
    input  pc_ce, if_id_ce, if_id_flush, id_ex_bubble, pipe_hold, mem_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_busy,
    output pc_ce, if_id_ce, if_id_flush, id_ex_bubble, pipe_hold, mem_timeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: zero-latency stall/flush/hold decisions; mem_busy holds the whole back end.
// Optional HAZARD_PERF_CNT_EN adds the stall_cycles performance counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES   = 1,
  parameter int unsigned MEM_WAIT_LIMIT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_LIMIT);

  logic [1:0] state, state_nxt;
  logic [1:0] fcnt, fcnt_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       timeout_q, timeout_nxt;

  logic lu;
  logic flushing;
  logic pc_ce_d, if_id_ce_d, if_id_flush_d, id_ex_bubble_d, pipe_hold_d;

  always_comb begin
    lu = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
         ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
          (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));
    // A flush interrupted by a memory wait is carried by a nonzero fcnt.
    flushing = (state == ST_FLUSH) || ((state == ST_MEM_WAIT) && (fcnt != 2'd0));
  end

  always_comb begin
    pc_ce_d        = 1'b1;
    if_id_ce_d     = 1'b1;
    if_id_flush_d  = 1'b0;
    id_ex_bubble_d = 1'b0;
    pipe_hold_d    = 1'b0;
    state_nxt      = ST_RUN;
    fcnt_nxt       = fcnt;
    wcnt_nxt       = 8'd0;
    timeout_nxt    = timeout_q;

    if (hz.mem_busy) begin
      pc_ce_d     = 1'b0;
      if_id_ce_d  = 1'b0;
      pipe_hold_d = 1'b1;
      state_nxt   = ST_MEM_WAIT;
      wcnt_nxt    = (wcnt == WAIT_LIMIT) ? wcnt : wcnt + 8'd1;
      if (wcnt_nxt == WAIT_LIMIT) begin
        timeout_nxt = 1'b1;
      end
    end else if (flushing) begin
      if_id_flush_d  = 1'b1;
      id_ex_bubble_d = 1'b1;
      fcnt_nxt       = fcnt - 2'd1;
      state_nxt      = (fcnt == 2'd1) ? ST_RUN : ST_FLUSH;
    end else if (hz.ex_branch_taken) begin
      if_id_flush_d  = 1'b1;
      id_ex_bubble_d = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_nxt = ST_FLUSH;
        fcnt_nxt  = FLUSH_INIT;
      end
    end else if (lu) begin
      pc_ce_d        = 1'b0;
      if_id_ce_d     = 1'b0;
      id_ex_bubble_d = 1'b1;
    end

    // Keep the pipeline inert and filled with NOPs while reset is held.
    if (!rst_n) begin
      pc_ce_d        = 1'b0;
      if_id_ce_d     = 1'b0;
      if_id_flush_d  = 1'b1;
      id_ex_bubble_d = 1'b1;
      pipe_hold_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      fcnt      <= 2'd0;
      wcnt      <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      fcnt      <= fcnt_nxt;
      wcnt      <= wcnt_nxt;
      timeout_q <= timeout_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 32'd0;
    end else if (!pc_ce_d) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

  assign hz.pc_ce        = pc_ce_d;
  assign hz.if_id_ce     = if_id_ce_d;
  assign hz.if_id_flush  = if_id_flush_d;
  assign hz.id_ex_bubble = id_ex_bubble_d;
  assign hz.pipe_hold    = pipe_hold_d;
  assign hz.mem_timeout  = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios plus random traffic against a cycle-count model.
module tb_pipeline_hazard_ctrl;
  localparam int FC  = 3;
  localparam int LIM = 8;

  logic clk;
  logic rst_n;
  pipeline_hazard_ctrl_if hif();
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_WAIT_LIMIT(LIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  // Model: remaining flush bubbles, consecutive busy cycles, sticky timeout, stall count.
  int pend   = 0;
  int brun   = 0;
  int m_stall = 0;
  bit m_to   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic mr,
                        input logic br, input logic busy);
    hif.id_rs1 = rs1;  hif.id_rs2 = rs2;
    hif.id_uses_rs1 = u1;  hif.id_uses_rs2 = u2;
    hif.ex_rd = rd;  hif.ex_mem_read = mr;
    hif.ex_branch_taken = br;  hif.mem_busy = busy;
  endtask

  function automatic logic [31:0] outs();
    return {27'd0, hif.pc_ce, hif.if_id_ce, hif.if_id_flush, hif.id_ex_bubble, hif.pipe_hold};
  endfunction

  // One clock cycle with the inputs already applied; checks outputs mid-cycle and state after the edge.
  task automatic cycle(input string tag);
    logic [4:0] e;
    logic lu;
    #2;
    lu = hif.ex_mem_read && hif.ex_rd != 0 &&
         ((hif.id_uses_rs1 && hif.id_rs1 == hif.ex_rd) ||
          (hif.id_uses_rs2 && hif.id_rs2 == hif.ex_rd));
    if (hif.mem_busy)             e = 5'b00001;
    else if (pend > 0)            e = 5'b11110;
    else if (hif.ex_branch_taken) e = 5'b11110;
    else if (lu)                  e = 5'b00010;
    else                          e = 5'b11000;
    check({tag, ".outs"}, outs(), {27'd0, e});
    @(posedge clk);
    if (!e[4]) m_stall++;
    if (hif.mem_busy) begin
      brun++;
      if (brun >= LIM) m_to = 1'b1;
    end else begin
      brun = 0;
      if (pend > 0) pend--;
      else if (hif.ex_branch_taken) pend = FC - 1;
    end
    #1;
    check({tag, ".timeout"}, {31'd0, hif.mem_timeout}, {31'd0, m_to});
`ifdef HAZARD_PERF_CNT_EN
    check({tag, ".stall_cnt"}, stall_cycles, m_stall);
`endif
  endtask

  task automatic reset_checks(input string tag);
    check({tag, ".forced"}, outs(), 32'b00110);
    check({tag, ".timeout"}, {31'd0, hif.mem_timeout}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check({tag, ".stall_cnt"}, stall_cycles, 32'd0);
`endif
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    pend = 0; brun = 0; m_stall = 0; m_to = 1'b0;
    #1;
    reset_checks(tag);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    reset_checks("por");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    set_in(1, 2, 1, 1, 3, 0, 0, 0);  cycle("normal");
    // Load-use on rs2: one bubble, then the load has moved on.
    set_in(7, 5, 1, 1, 5, 1, 0, 0);  cycle("lu_rs2");
    set_in(7, 5, 1, 1, 9, 0, 0, 0);  cycle("lu_after");
    set_in(5, 0, 1, 1, 5, 1, 0, 0);  cycle("lu_rs1");
    set_in(0, 0, 1, 1, 0, 1, 0, 0);  cycle("lu_rd0");
    set_in(5, 5, 0, 0, 5, 1, 0, 0);  cycle("lu_unused");

    // Taken branch: FC consecutive flush cycles with PC still advancing.
    set_in(0, 0, 0, 0, 0, 0, 1, 0);  cycle("br0");
    set_in(0, 0, 0, 0, 0, 0, 1, 0);  cycle("br1_ignored");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);  cycle("br2");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);  cycle("br_done");

    // Memory wait arriving mid-flush resumes the last flush cycle afterwards.
    set_in(0, 0, 0, 0, 0, 0, 1, 0);  cycle("mf_br");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);  cycle("mf_fl1");
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 1);  cycle("mf_busy");
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);  cycle("mf_resume");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);  cycle("mf_run");

    // Branch held by busy is acted on once the memory answers.
    set_in(0, 0, 0, 0, 0, 0, 1, 1);  cycle("bb_busy");
    set_in(0, 0, 0, 0, 0, 0, 1, 0);  cycle("bb_branch");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);  cycle("bb_fl1");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);  cycle("bb_fl2");

    // Wait timeout: rises on the LIM-th busy edge and is sticky until reset.
    pulse_reset("rst1");
    for (int i = 0; i < 10; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1);  cycle("to_busy");
    end
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0);  cycle("to_idle");
    end
    pulse_reset("rst2");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);  cycle("post_rst");

    for (int i = 0; i < 400; i++) begin
      set_in(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
             1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
             $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
      cycle("rand");
    end

    // Asynchronous reset in the middle of a memory wait.
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1);  cycle("rw_busy");
    end
`ifdef HAZARD_PERF_CNT_EN
    check("stall_before_rst", stall_cycles, m_stall);
`endif
    #2;
    pulse_reset("rst_midwait");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);  cycle("first_run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
